// File: rtl/bp_be_late_wb_arb_pkg.sv
// rtl/bp_be_late_wb_arb_pkg.sv - shared types and constants for the late writeback arbiter
// Purpose: writeback packet layout, its width, and the default starvation limit.
// Ports: none (package).
package bp_be_late_wb_arb_pkg;

   localparam int reg_addr_width_p       = 5;
   localparam int dword_width_p          = 64;
   localparam int starve_limit_default_p = 4;

   // Late writeback packet; forwarded unmodified from whichever source wins.
   typedef struct packed {
      logic                        ird_w_v;
      logic                        frd_w_v;
      logic                        late;
      logic [reg_addr_width_p-1:0] rd_addr;
      logic [dword_width_p-1:0]    rd_data;
   } bp_be_wb_pkt_s;

   localparam int wb_pkt_width_lp = $bits(bp_be_wb_pkt_s);

endpackage

// File: rtl/bp_be_late_wb_arb_if.sv
// rtl/bp_be_late_wb_arb_if.sv - bus bundle between memory/long pipes, arbiter and RF late ports
// Purpose: groups the packet, valid, yumi, credit and port-busy signals of both lanes.
// Ports (signals): mem_{i,f}wb_pkt_i/v_i, mem_credit_o, long_{i,f}wb_pkt_i/v_i/yumi_o,
//                  {i,f}wb_port_busy_i, {i,f}wb_pkt_o/pkt_v_o.
// Modports: master drives the arbiter inputs, slave is the arbiter itself.
interface bp_be_late_wb_arb_if;
   import bp_be_late_wb_arb_pkg::*;

   bp_be_wb_pkt_s mem_iwb_pkt_i;
   logic          mem_iwb_v_i;
   bp_be_wb_pkt_s mem_fwb_pkt_i;
   logic          mem_fwb_v_i;
   logic          mem_credit_o;

   bp_be_wb_pkt_s long_iwb_pkt_i;
   logic          long_iwb_v_i;
   logic          long_iwb_yumi_o;
   bp_be_wb_pkt_s long_fwb_pkt_i;
   logic          long_fwb_v_i;
   logic          long_fwb_yumi_o;

   logic          iwb_port_busy_i;
   logic          fwb_port_busy_i;
   bp_be_wb_pkt_s iwb_pkt_o;
   logic          iwb_pkt_v_o;
   bp_be_wb_pkt_s fwb_pkt_o;
   logic          fwb_pkt_v_o;

   modport master (
      output mem_iwb_pkt_i, mem_iwb_v_i, mem_fwb_pkt_i, mem_fwb_v_i,
      output long_iwb_pkt_i, long_iwb_v_i, long_fwb_pkt_i, long_fwb_v_i,
      output iwb_port_busy_i, fwb_port_busy_i,
      input  mem_credit_o, long_iwb_yumi_o, long_fwb_yumi_o,
      input  iwb_pkt_o, iwb_pkt_v_o, fwb_pkt_o, fwb_pkt_v_o
   );

   modport slave (
      input  mem_iwb_pkt_i, mem_iwb_v_i, mem_fwb_pkt_i, mem_fwb_v_i,
      input  long_iwb_pkt_i, long_iwb_v_i, long_fwb_pkt_i, long_fwb_v_i,
      input  iwb_port_busy_i, fwb_port_busy_i,
      output mem_credit_o, long_iwb_yumi_o, long_fwb_yumi_o,
      output iwb_pkt_o, iwb_pkt_v_o, fwb_pkt_o, fwb_pkt_v_o
   );

endinterface

// File: rtl/bp_be_late_wb_arb_lane.sv
// rtl/bp_be_late_wb_arb_lane.sv - one register-file lane: load queue, starvation counter, select
// Purpose: buffers late load packets and arbitrates them against the long pipe onto one RF port.
// Ports: clk_i, reset_i (sync, active-high); i_mem_pkt/i_mem_v (no backpressure);
//        i_long_pkt/i_long_v/o_long_yumi; i_port_busy; o_pkt/o_pkt_v; o_occ (queue occupancy).
module bp_be_late_wb_lane
   import bp_be_late_wb_arb_pkg::*;
#(
   parameter int els_p          = 2,
   parameter int starve_limit_p = starve_limit_default_p,
   localparam int occ_w_lp      = $clog2(els_p + 1)
)(
   input  logic                clk_i,
   input  logic                reset_i,
   input  bp_be_wb_pkt_s       i_mem_pkt,
   input  logic                i_mem_v,
   input  bp_be_wb_pkt_s       i_long_pkt,
   input  logic                i_long_v,
   output logic                o_long_yumi,
   input  logic                i_port_busy,
   output bp_be_wb_pkt_s       o_pkt,
   output logic                o_pkt_v,
   output logic [occ_w_lp-1:0] o_occ
);

   localparam int ptr_w_lp = $clog2(els_p);
   localparam int sw_lp    = $clog2(starve_limit_p + 1);
   localparam logic [ptr_w_lp-1:0] ptr_last_lp   = ptr_w_lp'(els_p - 1);
   localparam logic [occ_w_lp-1:0] occ_full_lp   = occ_w_lp'(els_p);
   localparam logic [sw_lp-1:0]    starve_max_lp = sw_lp'(starve_limit_p);

   bp_be_wb_pkt_s         r_mem [els_p];
   logic [ptr_w_lp-1:0]   r_wptr;
   logic [ptr_w_lp-1:0]   r_rptr;
   logic [occ_w_lp-1:0]   r_occ;
   logic [sw_lp-1:0]      r_starve;

   logic w_empty;
   logic w_full;
   logic w_sel_long;
   logic w_enq;
   logic w_deq;

   function automatic logic [ptr_w_lp-1:0] f_next(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_last_lp) ? '0 : p + 1'b1;
   endfunction

   assign w_empty = (r_occ == '0);
   assign w_full  = (r_occ == occ_full_lp);

   // Long pipe takes the port when nothing is queued, or once it has been
   // denied long enough; the valid term keeps a stale count from selecting it.
   assign w_sel_long  = w_empty | (i_long_v & (r_starve == starve_max_lp));
   assign o_pkt_v     = ~reset_i & ~i_port_busy & (~w_empty | i_long_v);
   assign o_pkt       = w_sel_long ? i_long_pkt : r_mem[r_rptr];
   assign o_long_yumi = o_pkt_v & w_sel_long;
   assign w_deq       = o_pkt_v & ~w_sel_long;

   // A write into a full queue is only accepted if the head leaves this cycle.
   assign w_enq = i_mem_v & (~w_full | w_deq);
   assign o_occ = r_occ;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_occ    <= '0;
         r_starve <= '0;
      end else begin
         if (w_enq) r_wptr <= f_next(r_wptr);
         if (w_deq) r_rptr <= f_next(r_rptr);
         if (w_enq & ~w_deq)      r_occ <= r_occ + 1'b1;
         else if (~w_enq & w_deq) r_occ <= r_occ - 1'b1;

         if (o_long_yumi | ~i_long_v)        r_starve <= '0;
         else if (r_starve != starve_max_lp) r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_enq) r_mem[r_wptr] <= i_mem_pkt;
   end

   // The memory pipe is credit-throttled; a write into a full queue with no
   // dequeue means the credit protocol was broken upstream.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(i_mem_v && w_full && !w_deq));

endmodule

// File: rtl/bp_be_late_wb_arb.sv
// rtl/bp_be_late_wb_arb.sv - late writeback arbiter for the integer and float register files
// Purpose: one lane per register file plus the memory-issue credit.
// Ports: clk_i, reset_i (sync, active-high); wb (slave modport of bp_be_late_wb_arb_if).
module bp_be_late_wb_arb
   import bp_be_late_wb_arb_pkg::*;
#(
   parameter int els_p          = 2,
   parameter int starve_limit_p = starve_limit_default_p
)(
   input  logic                      clk_i,
   input  logic                      reset_i,
   bp_be_late_wb_arb_if.slave        wb
);

   localparam int occ_w_lp = $clog2(els_p + 1);
   localparam logic [occ_w_lp-1:0] credit_lim_lp = occ_w_lp'(els_p - 1);

   logic [occ_w_lp-1:0] w_occ_i;
   logic [occ_w_lp-1:0] w_occ_f;

   bp_be_late_wb_lane #(.els_p(els_p), .starve_limit_p(starve_limit_p)) u_ilane (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .i_mem_pkt   (wb.mem_iwb_pkt_i),
      .i_mem_v     (wb.mem_iwb_v_i),
      .i_long_pkt  (wb.long_iwb_pkt_i),
      .i_long_v    (wb.long_iwb_v_i),
      .o_long_yumi (wb.long_iwb_yumi_o),
      .i_port_busy (wb.iwb_port_busy_i),
      .o_pkt       (wb.iwb_pkt_o),
      .o_pkt_v     (wb.iwb_pkt_v_o),
      .o_occ       (w_occ_i)
   );

   bp_be_late_wb_lane #(.els_p(els_p), .starve_limit_p(starve_limit_p)) u_flane (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .i_mem_pkt   (wb.mem_fwb_pkt_i),
      .i_mem_v     (wb.mem_fwb_v_i),
      .i_long_pkt  (wb.long_fwb_pkt_i),
      .i_long_v    (wb.long_fwb_v_i),
      .o_long_yumi (wb.long_fwb_yumi_o),
      .i_port_busy (wb.fwb_port_busy_i),
      .o_pkt       (wb.fwb_pkt_o),
      .o_pkt_v     (wb.fwb_pkt_v_o),
      .o_occ       (w_occ_f)
   );

   // One slot is held back for a load that is already in flight.
   assign wb.mem_credit_o = ~reset_i & (w_occ_i < credit_lim_lp) & (w_occ_f < credit_lim_lp);

endmodule

// File: tb/tb_bp_be_late_wb_arb.sv
// tb/tb_bp_be_late_wb_arb.sv - scoreboard bench for bp_be_late_wb_arb
module tb_bp_be_late_wb_arb;
   import bp_be_late_wb_arb_pkg::*;

   localparam int ELS = 2;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bp_be_late_wb_arb_if wb();

   bp_be_late_wb_arb #(.els_p(ELS), .starve_limit_p(LIM)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .wb      (wb.slave)
   );

   typedef struct {
      int            cyc;
      bp_be_wb_pkt_s pkt;
      logic          yumi;
   } exp_t;

   exp_t          exp_q [2][$];
   bp_be_wb_pkt_s mq    [2][$];
   int            starve [2];
   bit            cr_q  [$];
   int            cyc   = 0;
   int            tests = 0;
   int            fails = 0;

   logic          s_rst;
   logic          s_mv   [2];
   logic          s_lv   [2];
   logic          s_busy [2];
   bp_be_wb_pkt_s s_mpkt [2];
   bp_be_wb_pkt_s s_lpkt [2];
   logic          yumi_exp [2];

   function automatic bp_be_wb_pkt_s mk(input int rd, input logic [63:0] d, input bit fp);
      bp_be_wb_pkt_s p;
      p.ird_w_v = !fp;
      p.frd_w_v = fp;
      p.late    = 1'b1;
      p.rd_addr = rd[4:0];
      p.rd_data = d;
      return p;
   endfunction

   // Reference: per-lane packet queue plus a denial counter; outputs follow the
   // rules "queue first, long pipe when queue empty or after LIM denials".
   task automatic model();
      bit cr;
      if (s_rst) begin
         for (int l = 0; l < 2; l++) begin
            mq[l].delete();
            starve[l]   = 0;
            yumi_exp[l] = 1'b0;
         end
         cr_q.push_back(1'b0);
         return;
      end
      cr = (mq[0].size() < ELS - 1) && (mq[1].size() < ELS - 1);
      cr_q.push_back(cr);
      for (int l = 0; l < 2; l++) begin
         bit   lw, v, y;
         exp_t e;
         lw = (mq[l].size() == 0) || (s_lv[l] && starve[l] >= LIM);
         v  = !s_busy[l] && (mq[l].size() > 0 || s_lv[l]);
         y  = v && lw;
         if (v) begin
            e.cyc  = cyc;
            e.pkt  = lw ? s_lpkt[l] : mq[l][0];
            e.yumi = y;
            exp_q[l].push_back(e);
         end
         if (v && !lw) void'(mq[l].pop_front());
         starve[l] = (y || !s_lv[l]) ? 0 : ((starve[l] < LIM) ? starve[l] + 1 : LIM);
         if (s_mv[l] && mq[l].size() < ELS) mq[l].push_back(s_mpkt[l]);
         yumi_exp[l] = y;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      rst                = s_rst;
      wb.mem_iwb_v_i     = s_mv[0];
      wb.mem_iwb_pkt_i   = s_mpkt[0];
      wb.mem_fwb_v_i     = s_mv[1];
      wb.mem_fwb_pkt_i   = s_mpkt[1];
      wb.long_iwb_v_i    = s_lv[0];
      wb.long_iwb_pkt_i  = s_lpkt[0];
      wb.long_fwb_v_i    = s_lv[1];
      wb.long_fwb_pkt_i  = s_lpkt[1];
      wb.iwb_port_busy_i = s_busy[0];
      wb.fwb_port_busy_i = s_busy[1];
      model();
      // long-pipe packet retires once consumed
      for (int l = 0; l < 2; l++) if (yumi_exp[l]) s_lv[l] = 1'b0;
   endtask

   task automatic check_lane(input int l, input logic v, input bp_be_wb_pkt_s p, input logic y);
      bit   has;
      exp_t e;
      has = (exp_q[l].size() > 0) && (exp_q[l][0].cyc == cyc);
      tests++;
      if (v !== has) begin
         fails++;
         $display("FAIL valid lane%0d cyc%0d: got %b want %b", l, cyc, v, has);
      end else if (has) begin
         e = exp_q[l][0];
         if (p !== e.pkt || y !== e.yumi) begin
            fails++;
            $display("FAIL pkt lane%0d cyc%0d: got %h yumi %b want %h yumi %b",
                     l, cyc, p, y, e.pkt, e.yumi);
         end
      end else if (y !== 1'b0) begin
         fails++;
         $display("FAIL yumi lane%0d cyc%0d: got %b want 0", l, cyc, y);
      end
      if (has) void'(exp_q[l].pop_front());
   endtask

   always @(negedge clk) begin
      bit c;
      if (cr_q.size() > 0) begin
         c = cr_q.pop_front();
         tests++;
         if (wb.mem_credit_o !== c) begin
            fails++;
            $display("FAIL credit cyc%0d: got %b want %b", cyc, wb.mem_credit_o, c);
         end
         check_lane(0, wb.iwb_pkt_v_o, wb.iwb_pkt_o, wb.long_iwb_yumi_o);
         check_lane(1, wb.fwb_pkt_v_o, wb.fwb_pkt_o, wb.long_fwb_yumi_o);
      end
   end

   task automatic idle();
      s_rst = 1'b0;
      for (int l = 0; l < 2; l++) begin
         s_mv[l]   = 1'b0;
         s_busy[l] = 1'b0;
      end
   endtask

   initial begin
      bit cr;
      s_rst = 1'b1;
      for (int l = 0; l < 2; l++) begin
         s_mv[l] = 1'b0; s_lv[l] = 1'b0; s_busy[l] = 1'b0;
         s_mpkt[l] = '0; s_lpkt[l] = '0; starve[l] = 0; yumi_exp[l] = 1'b0;
      end

      // 1: reset, single integer load, one-cycle latency
      step(); step();
      idle(); step();
      s_mv[0] = 1'b1; s_mpkt[0] = mk(5, 64'hDEAD, 0); step();
      idle(); step(); step();

      // 2: port busy 3 cycles, two back-to-back loads, credit drops at occupancy 1
      s_busy[0] = 1'b1;
      s_mv[0] = 1'b1; s_mpkt[0] = mk(1, 64'h1, 0); step();
      s_mpkt[0] = mk(2, 64'h2, 0); step();
      s_mv[0] = 1'b0; step();
      idle(); step(); step(); step();

      // 3: long pipe held while queue refills every cycle -> yumi after LIM denials
      s_mv[0] = 1'b1; s_mpkt[0] = mk(10, 64'h10, 0); step();
      s_lv[0] = 1'b1; s_lpkt[0] = mk(7, 64'h77, 0);
      for (int i = 0; i < 7; i++) begin
         s_mpkt[0] = mk(11 + i, 64'h100 + i, 0);
         step();
      end
      idle(); step(); step(); step();

      // 4: empty float queue, long float packet goes straight through
      s_lv[1] = 1'b1; s_lpkt[1] = mk(3, 64'h33, 1); step();
      idle(); step();

      // 5: fill both queues, then enqueue+dequeue together across pointer wrap
      s_busy[0] = 1'b1; s_busy[1] = 1'b1;
      s_mv[0] = 1'b1; s_mv[1] = 1'b1;
      s_mpkt[0] = mk(20, 64'h20, 0); s_mpkt[1] = mk(20, 64'hF20, 1); step();
      s_mpkt[0] = mk(21, 64'h21, 0); s_mpkt[1] = mk(21, 64'hF21, 1); step();
      s_busy[0] = 1'b0; s_busy[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s_mpkt[0] = mk(22 + i, 64'h22 + i, 0);
         s_mpkt[1] = mk(22 + i, 64'hF22 + i, 1);
         step();
      end
      idle(); step(); step(); step();

      // 6: reset with two queued packets discards them
      s_busy[0] = 1'b1; s_busy[1] = 1'b1;
      s_mv[0] = 1'b1; s_mpkt[0] = mk(30, 64'h30, 0);
      s_mv[1] = 1'b1; s_mpkt[1] = mk(31, 64'h31, 1); step();
      s_mv[1] = 1'b0; s_mpkt[0] = mk(29, 64'h29, 0); step();
      s_mv[0] = 1'b0; s_rst = 1'b1; step(); step();
      idle(); step(); step(); step();

      // random traffic, mem issue gated by the modelled credit
      for (int n = 0; n < 400; n++) begin
         cr = (mq[0].size() < ELS - 1) && (mq[1].size() < ELS - 1);
         for (int l = 0; l < 2; l++) begin
            s_busy[l] = ($urandom_range(0, 3) == 0);
            s_mv[l]   = cr && ($urandom_range(0, 1) == 1);
            s_mpkt[l] = mk($urandom_range(0, 31), {$urandom(), $urandom()}, l == 1);
            if (!s_lv[l] && $urandom_range(0, 2) == 0) begin
               s_lv[l]   = 1'b1;
               s_lpkt[l] = mk($urandom_range(0, 31), {$urandom(), $urandom()}, l == 1);
            end
         end
         step();
      end

      idle();
      for (int l = 0; l < 2; l++) s_lv[l] = 1'b0;
      for (int i = 0; i < 6; i++) step();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bp_be_late_wb_arb.md
Name: bp_be_late_wb_arb

Overview:
- Sits directly downstream of the memory pipe's late writeback outputs.
- Buffers late integer and float load-writeback packets (valid-only, no backpressure) in small per-register-file queues.
- Arbitrates them against late packets from the long-latency pipe (valid/yumi) onto the single late write port of each register file.
- Throttles memory issue through a credit signal so the queues never overflow.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies vaddr_width_p, reg_addr_width_p and the writeback packet width.
- els_p, 2, queue depth per register file; must be at least 2.
- starve_limit_p, 4, consecutive cycles the long pipe may be denied before it gains priority.

Ports:
- clk_i  in  1  clock, all state on posedge.
- reset_i  in  1  synchronous, active-high reset.
- mem_iwb_pkt_i  in  wb_pkt_width_lp  late integer load packet from the memory pipe.
- mem_iwb_v_i  in  1  valid; cannot be stalled.
- mem_fwb_pkt_i  in  wb_pkt_width_lp  late float load packet.
- mem_fwb_v_i  in  1  valid; cannot be stalled.
- mem_credit_o  out  1  memory pipe may issue a load this cycle.
- long_iwb_pkt_i  in  wb_pkt_width_lp  long-pipe integer packet.
- long_iwb_v_i  in  1  valid.
- long_iwb_yumi_o  out  1  long-pipe integer packet consumed.
- long_fwb_pkt_i  in  wb_pkt_width_lp  long-pipe float packet.
- long_fwb_v_i  in  1  valid.
- long_fwb_yumi_o  out  1  long-pipe float packet consumed.
- iwb_port_busy_i  in  1  integer RF late port taken this cycle.
- fwb_port_busy_i  in  1  float RF late port taken this cycle.
- iwb_pkt_o  out  wb_pkt_width_lp  integer RF late write packet.
- iwb_pkt_v_o  out  1  integer RF write valid.
- fwb_pkt_o  out  wb_pkt_width_lp  float RF late write packet.
- fwb_pkt_v_o  out  1  float RF write valid.

Behaviour:
- Two identical lanes: integer (i) and float (f). The description below is per lane.
- Queue: FIFO of els_p entries with read/write pointers that wrap modulo els_p and an occupancy count of width clog2(els_p+1).
- Enqueue on mem_*_v_i with no ready check. Enqueue while full is a protocol error: simulation assertion fires, and the write is dropped with state unchanged.
- Latency: a packet enqueued in cycle N is eligible for output no earlier than cycle N+1. There is no bypass path.
- Output valid: pkt_v_o = ~port_busy_i & (occupancy != 0 | long_v_i). Output is combinational from the queue head or the long input.
- Select: queue head by default. The long input wins when occupancy == 0 or when starve_cnt == starve_limit_p.
- long_yumi_o = pkt_v_o & long selected. Dequeue = pkt_v_o & queue selected.
- starve_cnt:
  - Clears on long_yumi_o or on ~long_v_i.
  - Increments, saturating at starve_limit_p, when long_v_i and not yumi'd, whether because the queue won or the port was busy.
- Same-cycle enqueue and dequeue: occupancy unchanged, both pointers advance. This is legal when full.
- Credit: mem_credit_o = (occ_i < els_p-1) & (occ_f < els_p-1). This leaves one slot for a load already in flight.
- Outgoing packets are forwarded unmodified. The late and w_v fields come from the source.
- Reset:
  - Clears pointers, occupancy and starve_cnt.
  - While reset_i is high, all *_v_o and yumi outputs are 0 and mem_credit_o is 0.
  - In the first cycle after reset: mem_credit_o = 1, *_v_o = 0 (absent long inputs), yumi outputs = 0.
- Reset mid-operation discards queued packets. The surrounding core is also reset, so this is the required behaviour.
- There is no flush input. Late packets are already committed and are never squashed here.

Decomposition:
- Packet type bp_be_wb_pkt_s comes from the existing internal-interface struct declaration macro. No new typedefs.
- Add a default starvation-limit constant to bp_be_pkg.
- One sub-module, bp_be_late_wb_lane: queue, starvation counter and select for one register file. It is instantiated twice, for integer and float.
- Top level holds only the credit logic and the lane wiring.

Test Plan:
1. Reset, then a single mem_iwb_v_i with rd_addr 5, data 0xDEAD; port free, no long traffic -> iwb_pkt_v_o high exactly one cycle later with rd_addr 5, data 0xDEAD; occupancy returns to 0.
2. iwb_port_busy_i held high 3 cycles, 2 mem packets (rd 1, then rd 2) arriving back-to-back -> no output while busy; mem_credit_o low once occupancy reaches 1; after release, rd 1 then rd 2 on consecutive cycles; credit returns high.
3. long_iwb_v_i held high with rd 7 while a mem packet is enqueued every cycle, starve_limit_p = 4 -> queue wins 4 cycles, then long_iwb_yumi_o pulses on the 5th cycle with rd 7; starve_cnt returns to 0.
4. Queue empty, long_fwb_v_i with rd 3, fwb_port_busy_i low -> fwb_pkt_v_o and long_fwb_yumi_o high the same cycle; integer lane unaffected.
5. Full queue plus simultaneous enqueue and dequeue for 6 cycles -> no assertion, FIFO order preserved across pointer wrap.
6. Assert reset_i with 2 queued packets -> outputs and credit low during reset; after release, nothing drains and mem_credit_o = 1.
